// File: rtl/om_write_arbiter.sv
// om_write_arbiter: merges NUM_CH buffered write streams onto one object-map write port
module om_write_arbiter #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic [NUM_CH-1:0]        iWrreq,
  input  logic [NUM_CH*ADDR_W-1:0] iAddr,
  input  logic [NUM_CH*DATA_W-1:0] iData,
  input  logic                     iMode,
  input  logic                     iFlush,
  input  logic                     iWait_request,
  output logic [NUM_CH-1:0]        oFull,
  output logic [NUM_CH-1:0]        oOverflow,
  output logic                     oWrreq,
  output logic [ADDR_W-1:0]        oAddr,
  output logic [DATA_W-1:0]        oData,
  output logic [CHW-1:0]           oCh,
  output logic                     oIdle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;
  logic [EW-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [NUM_CH];
  logic [PW-1:0] rd_ptr [NUM_CH];
  logic [CW-1:0] count [NUM_CH];
  logic [CHW-1:0] rr_ptr, grant;
  logic [NUM_CH-1:0] push, pop, nonempty;
  logic any, free;
  assign free = !oWrreq || !iWait_request;
  assign oIdle = !oWrreq && nonempty == '0;
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      oFull[k] = count[k] == CW'(FIFO_DEPTH);
      nonempty[k] = count[k] != '0;
      push[k] = iWrreq[k] && !oFull[k] && !iFlush;
    end
  end
  // Search order starts at rr_ptr in round-robin mode, at channel 0 in fixed-priority mode.
  always_comb begin
    int c;
    c = 0;
    grant = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = iMode ? i : (int'(rr_ptr) + i) % NUM_CH;
      if (!any && nonempty[c]) begin
        grant = CHW'(c);
        any = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CH; k++)
      pop[k] = free && any && grant == CHW'(k);
  end
  always_ff @(posedge iClk) begin
    if (iReset || iFlush) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k] <= '0;
      end
      rr_ptr <= '0;
      oWrreq <= 1'b0;
      if (iReset) begin
        oAddr <= '0;
        oData <= '0;
        oCh <= '0;
        oOverflow <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= {iAddr[k*ADDR_W +: ADDR_W], iData[k*DATA_W +: DATA_W]};
          wr_ptr[k] <= wr_ptr[k] + 1'b1;
        end
        if (pop[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
        count[k] <= count[k] + CW'(push[k]) - CW'(pop[k]);
        if (iWrreq[k] && oFull[k]) oOverflow[k] <= 1'b1;
      end
      if (free) begin
        oWrreq <= any;
        if (any) begin
          {oAddr, oData} <= mem[grant][rd_ptr[grant]];
          oCh <= grant;
          if (!iMode) rr_ptr <= grant == CHW'(NUM_CH - 1) ? '0 : grant + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_om_write_arbiter.sv
// tb_om_write_arbiter: directed stimulus with a scoreboard of expected OM writes
module tb_om_write_arbiter;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  logic iClk, iReset, iMode, iFlush, iWait_request;
  logic [NUM_CH-1:0] iWrreq;
  logic [NUM_CH*ADDR_W-1:0] iAddr;
  logic [NUM_CH*DATA_W-1:0] iData;
  logic [NUM_CH-1:0] oFull, oOverflow;
  logic oWrreq, oIdle;
  logic [ADDR_W-1:0] oAddr;
  logic [DATA_W-1:0] oData;
  logic [1:0] oCh;
  int tests = 0;
  int fails = 0;
  logic [46:0] exp_q[$];
  logic [46:0] e;

  om_write_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .iClk(iClk), .iReset(iReset), .iWrreq(iWrreq), .iAddr(iAddr), .iData(iData),
    .iMode(iMode), .iFlush(iFlush), .iWait_request(iWait_request),
    .oFull(oFull), .oOverflow(oOverflow), .oWrreq(oWrreq), .oAddr(oAddr),
    .oData(oData), .oCh(oCh), .oIdle(oIdle)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] va(input int k, input int j, input int b);
    return ADDR_W'(b * 256 + k * 16 + j);
  endfunction

  function automatic logic [DATA_W-1:0] vd(input int k, input int j, input int b);
    return 32'hC0DE0000 | DATA_W'(b * 256 + k * 16 + j);
  endfunction

  task automatic put(input int k, input int j, input int b);
    iWrreq[k] = 1'b1;
    iAddr[k*ADDR_W +: ADDR_W] = va(k, j, b);
    iData[k*DATA_W +: DATA_W] = vd(k, j, b);
  endtask

  task automatic expect_wr(input int k, input int j, input int b);
    exp_q.push_back({2'(k), va(k, j, b), vd(k, j, b)});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && oIdle !== 1'b1; i++) tick();
    chk("drain_idle", 64'(oIdle), 1);
    chk("drain_sb", 64'(exp_q.size()), 0);
  endtask

  // A transfer completes at the next rising edge whenever oWrreq is high and the OM is not waiting.
  always @(negedge iClk) begin
    if (iReset === 1'b0 && iFlush === 1'b0 && oWrreq === 1'b1 && iWait_request === 1'b0) begin
      if (exp_q.size() == 0) chk("sb_pending", 64'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("sb_xfer", 64'({oCh, oAddr, oData}), 64'(e));
      end
    end
  end

  initial begin
    iReset = 1'b1; iMode = 1'b0; iFlush = 1'b0; iWait_request = 1'b0;
    iWrreq = '0; iAddr = '0; iData = '0;
    tick(); tick();
    iReset = 1'b0;
    chk("rst_wrreq", 64'(oWrreq), 0);
    chk("rst_addr", 64'(oAddr), 0);
    chk("rst_data", 64'(oData), 0);
    chk("rst_ch", 64'(oCh), 0);
    chk("rst_full", 64'(oFull), 0);
    chk("rst_ovf", 64'(oOverflow), 0);
    chk("rst_idle", 64'(oIdle), 1);
    // single write, two-edge latency
    iWrreq[1] = 1'b1;
    iAddr[ADDR_W +: ADDR_W] = 13'h0A5;
    iData[DATA_W +: DATA_W] = 32'hDEADBEEF;
    exp_q.push_back({2'd1, 13'h0A5, 32'hDEADBEEF});
    tick();
    iWrreq = '0;
    chk("lat_early", 64'(oWrreq), 0);
    tick();
    chk("lat_wrreq", 64'(oWrreq), 1);
    chk("lat_addr", 64'(oAddr), 64'h0A5);
    chk("lat_data", 64'(oData), 64'hDEADBEEF);
    chk("lat_ch", 64'(oCh), 1);
    tick();
    chk("lat_drop", 64'(oWrreq), 0);
    chk("lat_idle", 64'(oIdle), 1);
    iFlush = 1'b1; tick(); iFlush = 1'b0;
    // round-robin fairness
    iMode = 1'b0;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 3; k++) begin
        put(k, j, 1);
        expect_wr(k, j, 1);
      end
      tick();
    end
    iWrreq = '0;
    for (int i = 0; i < 6; i++) begin
      chk("rr_wrreq", 64'(oWrreq), 1);
      chk("rr_ch", 64'(oCh), 64'(i % 3));
      tick();
    end
    chk("rr_end", 64'(oWrreq), 0);
    // fixed priority
    iMode = 1'b1;
    for (int j = 0; j < 3; j++) expect_wr(0, j, 2);
    for (int j = 0; j < 3; j++) expect_wr(2, j, 2);
    for (int j = 0; j < 3; j++) begin
      put(0, j, 2);
      put(2, j, 2);
      tick();
      if (j > 0) chk("fp_ch0", 64'(oCh), 0);
    end
    iWrreq = '0;
    tick();
    chk("fp_ch0", 64'(oCh), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fp_wrreq", 64'(oWrreq), 1);
      chk("fp_ch2", 64'(oCh), 2);
    end
    tick();
    chk("fp_end", 64'(oWrreq), 0);
    // back-pressure
    iMode = 1'b0;
    put(0, 0, 3); expect_wr(0, 0, 3); tick();
    put(0, 1, 3); expect_wr(0, 1, 3); tick();
    iWrreq = '0;
    iWait_request = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_wrreq", 64'(oWrreq), 1);
      chk("bp_addr", 64'(oAddr), 64'(va(0, 0, 3)));
      chk("bp_data", 64'(oData), 64'(vd(0, 0, 3)));
      chk("bp_ch", 64'(oCh), 0);
      chk("bp_idle", 64'(oIdle), 0);
    end
    iWait_request = 1'b0;
    tick();
    chk("bp_next_wrreq", 64'(oWrreq), 1);
    chk("bp_next_addr", 64'(oAddr), 64'(va(0, 1, 3)));
    tick();
    chk("bp_end", 64'(oWrreq), 0);
    // overflow on ch2 while the OM stalls
    iWait_request = 1'b1;
    for (int j = 0; j < 6; j++) begin
      put(2, j, 4);
      if (j < 5) expect_wr(2, j, 4);
      tick();
      chk("ovf_full", 64'(oFull[2]), 64'(j >= 4));
      chk("ovf_flag", 64'(oOverflow[2]), 64'(j == 5));
    end
    iWrreq = '0;
    tick();
    iWait_request = 1'b0;
    drain();
    chk("ovf_kept", 64'(oOverflow), 64'b100);
    iFlush = 1'b1; tick(); iFlush = 1'b0;
    chk("ovf_after_flush", 64'(oOverflow), 64'b100);
    // flush mid-operation
    iWait_request = 1'b1;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 3; k++) put(k, j, 5);
      tick();
    end
    iWrreq = '0;
    chk("fl_busy", 64'(oWrreq), 1);
    iFlush = 1'b1; tick(); iFlush = 1'b0;
    chk("fl_wrreq", 64'(oWrreq), 0);
    chk("fl_full", 64'(oFull), 0);
    chk("fl_idle", 64'(oIdle), 1);
    chk("fl_ovf", 64'(oOverflow), 64'b100);
    // reset mid-operation
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 3; k++) put(k, j, 6);
      tick();
    end
    iWrreq = '0;
    chk("rs_busy", 64'(oWrreq), 1);
    iReset = 1'b1; tick(); iReset = 1'b0;
    iWait_request = 1'b0;
    chk("rs_wrreq", 64'(oWrreq), 0);
    chk("rs_full", 64'(oFull), 0);
    chk("rs_idle", 64'(oIdle), 1);
    chk("rs_ovf", 64'(oOverflow), 0);
    chk("rs_addr", 64'(oAddr), 0);
    put(2, 0, 7); expect_wr(2, 0, 7); tick();
    iWrreq = '0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/om_write_arbiter.md
Name: om_write_arbiter

Overview:
- Parametrised N-channel write merger in front of the object map (OM).
- Collects ANN-stage result writes (address + detection word) from NUM_CH scale pipelines and serialises them onto one OM write port.
- Per-channel FIFO buffering, round-robin or fixed-priority arbitration, downstream wait-request back-pressure, flush and sticky overflow flags.
- Lets the detection scale count grow beyond the current three without adding OM write ports.

Parameters:
- NUM_CH, 3, number of writer channels (1..8).
- ADDR_W, 13, OM address width.
- DATA_W, 32, OM data width.
- FIFO_DEPTH, 4, entries per channel FIFO (power of two, >=2).

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iWrreq  in  NUM_CH  per-channel write request; bit k = channel k.
- iAddr  in  NUM_CH*ADDR_W  per-channel address; channel k at bits [k*ADDR_W +: ADDR_W].
- iData  in  NUM_CH*DATA_W  per-channel data; channel k at bits [k*DATA_W +: DATA_W].
- iMode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- iFlush  in  1  synchronous flush of all buffered and pending writes.
- iWait_request  in  1  OM not accepting; output must hold.
- oFull  out  NUM_CH  channel FIFO full; writer must not assert iWrreq.
- oOverflow  out  NUM_CH  sticky: a write arrived while full and was dropped.
- oWrreq  out  1  OM write valid.
- oAddr  out  ADDR_W  OM write address.
- oData  out  DATA_W  OM write data.
- oCh  out  clog2(NUM_CH), min 1  source channel of the current oWrreq.
- oIdle  out  1  all FIFOs empty and oWrreq low.

Behaviour:
- Reset (iReset=1 at an edge): all FIFOs empty, counts 0; round-robin pointer = 0.
  - Outputs: oWrreq=0, oAddr=0, oData=0, oCh=0, oFull=0, oOverflow=0, oIdle=1.
  - Reset overrides every other input, including mid-transfer.
- Push: at an edge, channel k is written when iWrreq[k]=1 and oFull[k]=0.
  - oFull[k] = (count_k == FIFO_DEPTH), derived from registered state only.
  - A pop in the same cycle does not free the slot for that cycle's push.
- Overflow: iWrreq[k]=1 while oFull[k]=1 drops the entry and sets oOverflow[k]. It is cleared only by reset, not by flush.
- Output register: one holding stage.
  - It is "free" when oWrreq=0, or when oWrreq=1 and iWait_request=0 (transfer completes this edge).
  - When free and any FIFO is non-empty, the arbiter grants one channel, pops its head and loads oAddr/oData/oCh with oWrreq=1.
  - When free and all FIFOs are empty, oWrreq goes 0 and oAddr/oData/oCh hold their last values.
  - While oWrreq=1 and iWait_request=1, oAddr/oData/oCh/oWrreq stay stable; no pop occurs.
- Latency: an entry pushed into an empty system at edge t appears with oWrreq=1 after edge t+1 (2-cycle request-to-output).
- Throughput: one write per cycle sustained when iWait_request=0.
- Round-robin (iMode=0): search starts at pointer p and goes p, p+1, ... mod NUM_CH; first non-empty channel wins. After granting channel g, p <= (g+1) mod NUM_CH.
- Fixed priority (iMode=1): lowest-index non-empty channel wins. The pointer is not updated.
  - iMode is sampled at each arbitration; switching never corrupts the pointer.
- Flush (iFlush=1 at an edge, no reset): all FIFOs emptied, oWrreq<=0, pointer<=0; oOverflow retained.
  - Pushes in the same cycle are discarded without setting overflow.
- oIdle = (all counts 0) && !oWrreq, combinational from registers.
- Channel order is preserved per channel (FIFO). No ordering between channels is guaranteed beyond the arbitration rule.
- FIFO pointers wrap modulo FIFO_DEPTH; the count is a separate register of clog2(FIFO_DEPTH)+1 bits.

Test Plan:
- Single write: after reset, ch1 iWrreq for 1 cycle with addr=0x0A5, data=0xDEADBEEF.
  - Required: oWrreq=1 exactly 2 edges later for 1 cycle, oAddr=0x0A5, oData=0xDEADBEEF, oCh=1; oIdle returns to 1.
- Round-robin fairness: iMode=0, all three channels write 2 entries each, pushed simultaneously in two consecutive cycles; iWait_request=0.
  - Required: oCh sequence 0,1,2,0,1,2 on six consecutive cycles.
- Fixed priority: iMode=1, ch0 and ch2 each hold 3 entries.
  - Required: oCh 0,0,0,2,2,2.
- Back-pressure: iWait_request=1 for 5 cycles while oWrreq=1.
  - Required: oAddr/oData/oCh constant throughout, and no FIFO count decreases.
  - On release, the next entry follows on the next cycle.
- Overflow: FIFO_DEPTH=4, iWait_request held 1; ch2 pushes 6 consecutive entries.
  - Required: oFull[2]=1 after 4 accepted entries (a 5th is held in the output stage only if arbitration popped it); oOverflow[2]=1 and stays 1 after iFlush.
  - Drained order matches push order, with the dropped entries missing.
- Reset/flush mid-operation: with 3 entries buffered and oWrreq=1, assert iReset (or iFlush) for 1 cycle.
  - Required: next cycle oWrreq=0, oFull=0, oIdle=1.
  - Reset also clears oOverflow; flush keeps it.
